streebog_stream_feeder: RTL and testbench
=========================================

# streebog_stream_feeder

Hardware front-end that turns a 32-bit message word stream into the `init`/`update`/`final` command sequence expected by `streebog_hash_top`. It does the following:
- packs words into 512-bit blocks;
- applies Streebog padding to the last partial block;
- issues a block update each time a block is complete or the message ends;
- returns the captured digest to the requester.

It sits between a bus/DMA source and the hash core, replacing software sequencing.

## Interface
Parameters:
- none (block width 512, word width 32 fixed by the core)

Ports:
- clock  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new message. Accepted only in IDLE.
- start_short_mode  in  1  sampled with `start`; 1 = 256-bit digest, 0 = 512-bit.
- s_data  in  32  message word; byte 0 (first message byte) is `s_data[7:0]`.
- s_valid  in  1  `s_data` valid.
- s_last  in  1  final word of the message.
- s_bytes  in  2  valid bytes in the last word, counted from `s_data[7:0]`; 0 means 4. Ignored unless `s_last`.
- s_ready  out  1  word accepted when `s_valid & s_ready`.
- core_block  out  512  block to core; word k sits at bits `[32k+31:32k]`.
- core_block_length  out  10  valid message bits in `core_block`: 0..512.
- core_init  out  1  one-cycle pulse to core.
- core_update  out  1  one-cycle pulse to core.
- core_final  out  1  one-cycle pulse to core.
- core_short_mode  out  1  registered mode bit to core.
- core_digest  in  512  from core.
- core_digest_valid  in  1  from core.
- core_ready  in  1  from core.
- hash  out  512  captured digest.
- hash_valid  out  1  level; high from capture until the next `start`.
- busy  out  1  high in every state except IDLE.

## Operation
FSM states: IDLE, INIT, FILL, UPD, UPD_WAIT, PAD, FIN, FIN_WAIT, RDY_WAIT.

- **IDLE**
  - On `start`: latch mode into `core_short_mode`, clear the buffer and word counter `wcnt` (4 bits), clear `hash_valid`, then go to INIT.
  - `start` in any other state is ignored.
- **INIT**
  - Pulse `core_init` for one cycle, then go to FILL.
- **FILL**
  - `s_ready` = 1.
  - Each accepted word is written at slot `wcnt`, and `wcnt` increments (wraps 15 -> 0).
  - Full block (16th word, not `s_last`): length = 512, then go to UPD, with `pad_pending` = 0 and `last` = 0.
  - `s_last`: let b = `s_bytes`, with 0 treated as 4, and n = 4·`wcnt` + b bytes in the block.
    - If n < 64: write byte 0x01 at byte n, zero-fill above it, set length = 8n, set `last` = 1, then go to UPD.
    - If n = 64: set length = 512, `last` = 1, `pad_pending` = 1, then go to UPD.
  - Bytes above b in the last word are forced to zero, never taken from `s_data`.
- **UPD**
  - Pulse `core_update`, then go to UPD_WAIT.
- **UPD_WAIT**
  - Ignore `core_ready` on the first cycle, then wait for `core_ready` = 1.
  - Next state: PAD if `pad_pending`, else FIN if `last`, else clear the buffer, set `wcnt` = 0 and go to FILL.
- **PAD**
  - Load block = 512'h…01 (byte 0 = 0x01, rest zero), length = 0, clear `pad_pending`, then go to UPD.
- **FIN**
  - Pulse `core_final`, then go to FIN_WAIT.
- **FIN_WAIT**
  - Ignore the first cycle, then wait for `core_digest_valid`.
  - Capture `hash` in that cycle, set `hash_valid`, then go to RDY_WAIT.
- **RDY_WAIT**
  - Wait for `core_ready` = 1, then go to IDLE.

Empty messages are not supported; every message carries at least one byte.

## Timing
Reset values:
- all outputs 0, including `core_block`, `core_block_length` and `hash`;
- FSM in IDLE.

Cycle-level behaviour:
- `start` -> `core_init` is 1 cycle later; FILL is entered 2 cycles after `start`.
- `s_ready` is registered and combinationally independent of `s_valid`. It deasserts the cycle after the block-completing or `s_last` handshake.
- `core_update` is asserted the cycle after the completing handshake. `core_block` and `core_block_length` are stable from that cycle until the core returns ready.
- Pulses are exactly one cycle, and only one of `core_init`/`core_update`/`core_final` is high at a time.
- `hash` is updated in the cycle after `core_digest_valid` is sampled. `busy` drops when IDLE is re-entered.
- Reset mid-operation: returns to IDLE immediately; the core must be re-initialised by the next `start`.

## Configuration
`STREEBOG_FEEDER_SHORT_ALIGN_EN`:
- Defined: in short mode, `hash[255:0]` = `core_digest[511:256]` and `hash[511:256]` = 0.
- Undefined: `hash` = `core_digest` verbatim in both modes; the 256-bit result is left in `hash[511:256]`.
- Long mode is identical either way.

## Test plan
- 63-byte message "012345678901…" (GOST M1), 16 words, last word `s_bytes` = 3, long mode:
  - exactly one update, with length = 504 and byte 63 = 0x01;
  - `hash` = 486f64c1…1ad0541b.
- Same message in short mode:
  - with macro, `hash[255:0]` = 00557be5…ef1e159d;
  - without macro, `hash[511:256]` = 00557be5…ef1e159d.
- 72-byte GOST M2 message (18 words), long mode:
  - two updates, with lengths 512 then 64;
  - `hash` = 28fbc9ba…22e6881e;
  - short mode gives 508f7e55…4efed29d.
- 64-byte message (16 words, `s_last` on the 16th, `s_bytes` = 0):
  - two updates, with lengths 512 then 0, second block = 512'h…01;
  - then `core_final`.
- Back-pressure and reset:
  - `core_ready` held low for 20 cycles: `s_ready` stays 0 and `core_block` is stable throughout;
  - `reset_n` pulsed low in FIN_WAIT: all outputs return to 0 and the FSM goes to IDLE;
  - a new M1 run after that reset passes.

Source files
------------

// File: rtl/streebog_stream_feeder.sv
// Packs a 32-bit word stream into padded 512-bit blocks and sequences init/update/final for streebog_hash_top.
// Option STREEBOG_FEEDER_SHORT_ALIGN_EN: right-align the 256-bit digest in hash[255:0] in short mode.
module streebog_stream_feeder (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         start,
   input  logic         start_short_mode,
   input  logic [31:0]  s_data,
   input  logic         s_valid,
   input  logic         s_last,
   input  logic [1:0]   s_bytes,
   output logic         s_ready,
   output logic [511:0] core_block,
   output logic [9:0]   core_block_length,
   output logic         core_init,
   output logic         core_update,
   output logic         core_final,
   output logic         core_short_mode,
   input  logic [511:0] core_digest,
   input  logic         core_digest_valid,
   input  logic         core_ready,
   output logic [511:0] hash,
   output logic         hash_valid,
   output logic         busy
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_INIT     = 4'd1;
   localparam logic [3:0] S_FILL     = 4'd2;
   localparam logic [3:0] S_UPD      = 4'd3;
   localparam logic [3:0] S_UPD_WAIT = 4'd4;
   localparam logic [3:0] S_PAD      = 4'd5;
   localparam logic [3:0] S_FIN      = 4'd6;
   localparam logic [3:0] S_FIN_WAIT = 4'd7;
   localparam logic [3:0] S_RDY_WAIT = 4'd8;

   logic [3:0]        state;
   logic [15:0][31:0] blk;
   logic [63:0][7:0]  blk_b;
   logic [63:0][7:0]  blk_last;
   logic [3:0]        wcnt;
   logic              pad_pending;
   logic              last;
   logic              first;
   logic              handshake;
   logic [2:0]        nb;
   logic [6:0]        base;
   logic [6:0]        nbytes;
   logic [511:0]      hash_cap;

   assign handshake  = s_valid & s_ready;
   assign nb         = (s_bytes == 2'd0) ? 3'd4 : {1'b0, s_bytes};
   assign base       = {1'b0, wcnt, 2'b00};
   assign nbytes     = base + {4'b0, nb};
   assign blk_b      = blk;
   assign core_block = blk;
   assign busy       = (state != S_IDLE);

   // Final block image: message bytes, then the 0x01 marker, zeros above; bytes of s_data past b never leak in.
   always_comb begin
      blk_last = blk_b;
      for (int i = 0; i < 64; i++) begin
         if (7'(i) >= base) begin
            if (7'(i) < nbytes)
               blk_last[i] = s_data[8*(i%4) +: 8];
            else if (7'(i) == nbytes)
               blk_last[i] = 8'h01;
            else
               blk_last[i] = 8'h00;
         end
      end
   end

   always_comb begin
      hash_cap = core_digest;
`ifdef STREEBOG_FEEDER_SHORT_ALIGN_EN
      if (core_short_mode)
         hash_cap = {256'b0, core_digest[511:256]};
`endif
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state             <= S_IDLE;
         blk               <= '0;
         wcnt              <= '0;
         pad_pending       <= 1'b0;
         last              <= 1'b0;
         first             <= 1'b0;
         s_ready           <= 1'b0;
         core_block_length <= '0;
         core_init         <= 1'b0;
         core_update       <= 1'b0;
         core_final        <= 1'b0;
         core_short_mode   <= 1'b0;
         hash              <= '0;
         hash_valid        <= 1'b0;
      end else begin
         core_init   <= 1'b0;
         core_update <= 1'b0;
         core_final  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  core_short_mode <= start_short_mode;
                  blk             <= '0;
                  wcnt            <= '0;
                  pad_pending     <= 1'b0;
                  last            <= 1'b0;
                  hash_valid      <= 1'b0;
                  core_init       <= 1'b1;
                  state           <= S_INIT;
               end
            end
            S_INIT: begin
               s_ready <= 1'b1;
               state   <= S_FILL;
            end
            S_FILL: begin
               if (handshake) begin
                  wcnt <= wcnt + 4'd1;
                  if (s_last) begin
                     blk         <= blk_last;
                     last        <= 1'b1;
                     s_ready     <= 1'b0;
                     core_update <= 1'b1;
                     state       <= S_UPD;
                     // A message ending exactly on a block boundary needs a separate marker-only block.
                     if (nbytes == 7'd64) begin
                        core_block_length <= 10'd512;
                        pad_pending       <= 1'b1;
                     end else begin
                        core_block_length <= {nbytes, 3'b000};
                     end
                  end else begin
                     blk[wcnt] <= s_data;
                     if (wcnt == 4'd15) begin
                        core_block_length <= 10'd512;
                        pad_pending       <= 1'b0;
                        last              <= 1'b0;
                        s_ready           <= 1'b0;
                        core_update       <= 1'b1;
                        state             <= S_UPD;
                     end
                  end
               end
            end
            S_UPD: begin
               first <= 1'b1;
               state <= S_UPD_WAIT;
            end
            S_UPD_WAIT: begin
               if (first) begin
                  first <= 1'b0;
               end else if (core_ready) begin
                  if (pad_pending) begin
                     state <= S_PAD;
                  end else if (last) begin
                     core_final <= 1'b1;
                     state      <= S_FIN;
                  end else begin
                     blk     <= '0;
                     wcnt    <= '0;
                     s_ready <= 1'b1;
                     state   <= S_FILL;
                  end
               end
            end
            S_PAD: begin
               blk               <= 512'h1;
               core_block_length <= 10'd0;
               pad_pending       <= 1'b0;
               core_update       <= 1'b1;
               state             <= S_UPD;
            end
            S_FIN: begin
               first <= 1'b1;
               state <= S_FIN_WAIT;
            end
            S_FIN_WAIT: begin
               if (first) begin
                  first <= 1'b0;
               end else if (core_digest_valid) begin
                  hash       <= hash_cap;
                  hash_valid <= 1'b1;
                  state      <= S_RDY_WAIT;
               end
            end
            S_RDY_WAIT: begin
               if (core_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_streebog_stream_feeder.sv
// Bench for streebog_stream_feeder: behavioural core stand-in, padding model and per-cycle block/handshake checks.
module tb_streebog_stream_feeder;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         start, start_short_mode;
   logic [31:0]  s_data;
   logic         s_valid, s_last;
   logic [1:0]   s_bytes;
   logic         s_ready;
   logic [511:0] core_block;
   logic [9:0]   core_block_length;
   logic         core_init, core_update, core_final, core_short_mode;
   logic [511:0] core_digest;
   logic         core_digest_valid, core_ready;
   logic [511:0] hash;
   logic         hash_valid, busy;

   always #5 clock = ~clock;

   streebog_stream_feeder dut (
      .clock(clock), .reset_n(reset_n), .start(start), .start_short_mode(start_short_mode),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_bytes(s_bytes), .s_ready(s_ready),
      .core_block(core_block), .core_block_length(core_block_length), .core_init(core_init),
      .core_update(core_update), .core_final(core_final), .core_short_mode(core_short_mode),
      .core_digest(core_digest), .core_digest_valid(core_digest_valid), .core_ready(core_ready),
      .hash(hash), .hash_valid(hash_valid), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   logic [7:0]   msg [0:127];
   logic [511:0] exp_blk [0:3];
   logic [9:0]   exp_len [0:3];
   int           exp_n = 0;
   logic [511:0] seen_blk [0:7];
   logic [9:0]   seen_len [0:7];
   int           upd_idx = 0;
   int           upd_dly = 3;
   int           fin_dly = 4;
   int           run = 0;
   logic [511:0] digest_next = '0;

   // Core stand-in: update/final drop ready for a while; final ends with a one-cycle digest.
   int ccnt;
   int cmode;
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         core_ready <= 1'b1; core_digest_valid <= 1'b0; core_digest <= '0; ccnt <= 0; cmode <= 0;
      end else begin
         core_digest_valid <= 1'b0;
         if (core_update) begin
            core_ready <= 1'b0; ccnt <= upd_dly; cmode <= 1;
         end else if (core_final) begin
            core_ready <= 1'b0; ccnt <= fin_dly; cmode <= 2;
         end else if (cmode != 0) begin
            if (ccnt > 0) ccnt <= ccnt - 1;
            else begin
               core_ready <= 1'b1;
               cmode      <= 0;
               if (cmode == 2) begin
                  core_digest_valid <= 1'b1;
                  core_digest       <= digest_next;
               end
            end
         end
      end
   end

   // Per-cycle compare: every update against the padding model, and hold/back-pressure while the core is busy.
   logic         waiting = 1'b0;
   logic [511:0] held_blk;
   logic [9:0]   held_len;
   always @(negedge clock) begin
      if (!reset_n) begin
         waiting <= 1'b0;
      end else begin
         check("pulse_excl", 512'($countones({core_init, core_update, core_final}) > 1), 512'd0);
         if (start) upd_idx <= 0;
         if (core_update) begin
            if (upd_idx < exp_n) begin
               check("upd_blk", core_block, exp_blk[upd_idx]);
               check("upd_len", 512'(core_block_length), 512'(exp_len[upd_idx]));
            end
            if (upd_idx < 8) begin
               seen_blk[upd_idx] <= core_block;
               seen_len[upd_idx] <= core_block_length;
            end
            upd_idx  <= upd_idx + 1;
            waiting  <= 1'b1;
            held_blk <= core_block;
            held_len <= core_block_length;
         end else if (waiting) begin
            check("hold_blk", core_block, held_blk);
            check("hold_len", 512'(core_block_length), 512'(held_len));
            check("hold_sready", 512'(s_ready), 512'd0);
            if (core_ready) waiting <= 1'b0;
         end
      end
   end

   task automatic fill_msg(input int kind, input int len);
      for (int i = 0; i < 128; i++) begin
         case (kind)
            0:       msg[i] = (i < len) ? 8'(8'h30 + i % 10) : 8'h00;
            1:       msg[i] = (i < len) ? 8'(i * 37 + 11) : 8'h00;
            default: msg[i] = (i < len) ? 8'(i ^ 8'h5A) : 8'h00;
         endcase
      end
   endtask

   // Streebog padding: 512-bit chunks, then the remainder with a 0x01 marker (marker-only block if none left).
   task automatic build_exp(input int len);
      logic [511:0] b;
      int nfull, rem;
      nfull = len / 64;
      rem   = len % 64;
      exp_n = 0;
      for (int k = 0; k < nfull; k++) begin
         b = '0;
         for (int i = 0; i < 64; i++) b[8*i +: 8] = msg[64*k + i];
         exp_blk[exp_n] = b;
         exp_len[exp_n] = 10'd512;
         exp_n++;
      end
      b = '0;
      for (int i = 0; i < rem; i++) b[8*i +: 8] = msg[64*nfull + i];
      b[8*rem +: 8]  = 8'h01;
      exp_blk[exp_n] = b;
      exp_len[exp_n] = 10'(8 * rem);
      exp_n++;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_block"}, core_block, 512'd0);
      check({tag, "_len"}, 512'(core_block_length), 512'd0);
      check({tag, "_hash"}, hash, 512'd0);
      check({tag, "_ctl"}, 512'({s_ready, core_init, core_update, core_final, core_short_mode, hash_valid, busy}), 512'd0);
   endtask

   task automatic run_msg(input int len, input bit sm, input bit abort_fin);
      logic [511:0] exp_hash;
      logic [31:0]  w32;
      int nw, t, idx;
      run++;
      build_exp(len);
      for (int w = 0; w < 16; w++)
         digest_next[32*w +: 32] = (32'h9E3779B9 * 32'(w + 1)) ^ 32'(run * 1000 + len);
      exp_hash = digest_next;
`ifdef STREEBOG_FEEDER_SHORT_ALIGN_EN
      if (sm) exp_hash = {256'b0, digest_next[511:256]};
`endif
      @(posedge clock); #1 start = 1'b1; start_short_mode = sm;
      @(posedge clock); #1 start = 1'b0; start_short_mode = 1'b0;
      check("init_pulse", 512'(core_init), 512'd1);
      check("hash_valid_clr", 512'(hash_valid), 512'd0);
      check("busy_run", 512'(busy), 512'd1);
      @(posedge clock); #1;
      check("init_done", 512'(core_init), 512'd0);
      check("fill_ready", 512'(s_ready), 512'd1);
      check("mode", 512'(core_short_mode), 512'(sm));
      nw = (len + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         for (int b = 0; b < 4; b++) begin
            idx = 4 * w + b;
            w32[8*b +: 8] = (idx < len) ? msg[idx] : 8'hEE;
         end
         s_data  = w32;
         s_valid = 1'b1;
         s_last  = (w == nw - 1);
         s_bytes = (w == nw - 1) ? 2'(len % 4) : 2'(w + 1);
         t = 0;
         while (!s_ready && t < 200) begin @(posedge clock); #1; t++; end
         if (t >= 200) check("sready_timeout", 512'(t), 512'd0);
         @(posedge clock); #1;
      end
      s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_bytes = '0;
      if (abort_fin) begin
         t = 0;
         while (!core_final && t < 500) begin @(posedge clock); #1; t++; end
         if (t >= 500) check("final_timeout", 512'(t), 512'd0);
         @(posedge clock); #1;
         reset_n = 1'b0;
         #1 check_reset_outputs("midrst");
         @(posedge clock); #1 reset_n = 1'b1;
         @(posedge clock); #1 check_reset_outputs("postrst");
         return;
      end
      t = 0;
      while (!hash_valid && t < 2000) begin @(posedge clock); #1; t++; end
      if (t >= 2000) check("hash_timeout", 512'(t), 512'd0);
      check("hash", hash, exp_hash);
      check("upd_count", 512'(upd_idx), 512'(exp_n));
      t = 0;
      while (busy && t < 100) begin @(posedge clock); #1; t++; end
      check("idle_after", 512'(busy), 512'd0);
      check("hash_valid_hold", 512'(hash_valid), 512'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; start_short_mode = 1'b0;
      s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_bytes = '0;
      repeat (3) @(posedge clock);
      #1 check_reset_outputs("reset");
      reset_n = 1'b1;
      @(posedge clock); #1;

      // 63-byte message: a single update, length 504, marker in byte 63.
      fill_msg(0, 63); run_msg(63, 1'b0, 1'b0);
      check("m1_len", 512'(seen_len[0]), 512'd504);
      check("m1_marker", 512'(seen_blk[0][511:504]), 512'h01);
      check("m1_nupd", 512'(upd_idx), 512'd1);
      run_msg(63, 1'b1, 1'b0);

      // 72-byte message with a slow core: 512 then 64 bits.
      fill_msg(1, 72); upd_dly = 20;
      run_msg(72, 1'b0, 1'b0);
      check("m2_len0", 512'(seen_len[0]), 512'd512);
      check("m2_len1", 512'(seen_len[1]), 512'd64);
      upd_dly = 3;
      run_msg(72, 1'b1, 1'b0);

      // Exactly one block: data block then a marker-only block of length 0.
      fill_msg(2, 64); run_msg(64, 1'b0, 1'b0);
      check("b64_len0", 512'(seen_len[0]), 512'd512);
      check("b64_len1", 512'(seen_len[1]), 512'd0);
      check("b64_pad", seen_blk[1], 512'h1);

      fill_msg(1, 5);  run_msg(5, 1'b0, 1'b0);
      check("m5_len", 512'(seen_len[0]), 512'd40);
      fill_msg(2, 60); run_msg(60, 1'b1, 1'b0);
      check("m60_marker", 512'(seen_blk[0][487:480]), 512'h01);

      // Reset while waiting for the digest, then a clean run.
      fill_msg(0, 63); run_msg(63, 1'b0, 1'b1);
      run_msg(63, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
